// File: rtl/router_fifo_depacketizer.sv
// Receive side of the router<->FIFO packet protocol: buffers router flits under on/off
// flow control and rebuilds packets (header + len+1 payload words) for the DLA ingress FIFO.

package router_fifo_depacketizer_pkg;
    localparam int FLIT_DATA_SIZE = 32;
    localparam int VC_NUM         = 2;
    localparam int VC_SIZE        = 1;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    // Head flit data layout: {x_dest[3:0], y_dest[3:0], head_pl}, len in the top 5 bits of head_pl
    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_SIZE-1:0]         vc_id;
        logic [FLIT_DATA_SIZE-1:0]  data;
    } flit_t;
endpackage

// state   | meaning
// IDLE    | waiting for a HEAD/HEADTAIL flit to open a packet
// PAYLOAD | header written, forwarding payload until cnt reaches len
module router_fifo_depacketizer
    import router_fifo_depacketizer_pkg::*;
#(
    parameter int BUF_DEPTH     = 4,
    parameter int ON_OFF_MARGIN = 2
) (
    input  logic                      clk_router,
    input  logic                      rst_router,
    input  flit_t                     router_data_out,
    input  logic                      router_valid_out,
    output logic [VC_NUM-1:0]         router_is_on_off_in,
    output logic [VC_NUM-1:0]         router_is_allocatable_in,
    output logic                      fifo_wr_en,
    output logic [FLIT_DATA_SIZE-1:0] fifo_wr_data,
    input  logic                      fifo_afull,
    output logic                      pkt_done,
    output logic                      pkt_err,
    output logic [4:0]                pkt_len
);

    localparam int PTR_W   = $clog2(BUF_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LEN_MSB = FLIT_DATA_SIZE - 9;

    typedef enum logic {
        S_IDLE,
        S_PAYLOAD
    } state_t;

    flit_t              buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               overflow;
    flit_t              head;

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         cnt;
    logic [4:0]         cnt_nxt;
    logic [4:0]         len_nxt;
    logic               wr_en_d;
    logic [FLIT_DATA_SIZE-1:0] wr_data_d;
    logic               done_d;
    logic               err_d;
    logic               unused_vc;

    assign unused_vc = ^router_data_out.vc_id;

    assign full     = (count == CNT_W'(BUF_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && !fifo_afull;
    // A push at full is accepted only when a pop frees the slot in the same cycle
    assign push     = router_valid_out && (!full || pop);
    assign overflow = router_valid_out && full && !pop;
    assign head     = buf_mem[rd_ptr];

    assign router_is_on_off_in      = {VC_NUM{(CNT_W'(BUF_DEPTH) - count) > CNT_W'(ON_OFF_MARGIN)}};
    assign router_is_allocatable_in = {VC_NUM{1'b1}};

    always_ff @(posedge clk_router) begin
        if (push) begin
            buf_mem[wr_ptr] <= router_data_out;
        end
    end

    always_ff @(posedge clk_router or posedge rst_router) begin
        if (rst_router) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_router or posedge rst_router) begin
        if (rst_router) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (pop) begin
            case (head.flit_label)
                HEAD:     state_nxt = S_PAYLOAD;
                HEADTAIL: state_nxt = S_IDLE;
                BODY: begin
                    if (state == S_PAYLOAD && cnt == pkt_len) begin
                        state_nxt = S_IDLE;
                    end
                end
                TAIL:     state_nxt = S_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = head.data;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_nxt   = cnt;
        len_nxt   = pkt_len;
        if (pop) begin
            case (head.flit_label)
                HEAD: begin
                    wr_en_d = 1'b1;
                    len_nxt = head.data[LEN_MSB -: 5];
                    cnt_nxt = '0;
                    err_d   = (state == S_PAYLOAD);
                end
                HEADTAIL: begin
                    wr_en_d = 1'b1;
                    err_d   = 1'b1;
                end
                BODY: begin
                    if (state == S_IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        if (cnt == pkt_len) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (state == S_IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        done_d  = (cnt == pkt_len);
                        err_d   = (cnt != pkt_len);
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_router or posedge rst_router) begin
        if (rst_router) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            pkt_done     <= 1'b0;
            pkt_err      <= 1'b0;
            pkt_len      <= '0;
            cnt          <= '0;
        end else begin
            fifo_wr_en <= wr_en_d;
            if (wr_en_d) begin
                fifo_wr_data <= wr_data_d;
            end
            pkt_done <= done_d;
            pkt_err  <= err_d || overflow;
            pkt_len  <= len_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_router_fifo_depacketizer.sv
// Directed table-driven bench for router_fifo_depacketizer: per-cycle input rows with
// hand-computed expected FIFO writes, pulses, on/off and pkt_len.

module tb_router_fifo_depacketizer;
    import router_fifo_depacketizer_pkg::*;

    typedef struct {
        bit          v;
        logic [1:0]  label;
        logic [31:0] data;
        bit          afull;
        bit          wr;
        logic [31:0] wdata;
        bit          done;
        bit          err;
        bit          on;
        logic [4:0]  len;
    } vec_t;

    logic                      clk_router = 1'b0;
    logic                      rst_router = 1'b1;
    flit_t                     router_data_out;
    logic                      router_valid_out = 1'b0;
    logic [VC_NUM-1:0]         router_is_on_off_in;
    logic [VC_NUM-1:0]         router_is_allocatable_in;
    logic                      fifo_wr_en;
    logic [FLIT_DATA_SIZE-1:0] fifo_wr_data;
    logic                      fifo_afull = 1'b0;
    logic                      pkt_done;
    logic                      pkt_err;
    logic [4:0]                pkt_len;

    int checks   = 0;
    int failures = 0;
    vec_t tab1[$];
    vec_t tab2[$];

    router_fifo_depacketizer #(.BUF_DEPTH(4), .ON_OFF_MARGIN(2)) dut (
        .clk_router              (clk_router),
        .rst_router              (rst_router),
        .router_data_out         (router_data_out),
        .router_valid_out        (router_valid_out),
        .router_is_on_off_in     (router_is_on_off_in),
        .router_is_allocatable_in(router_is_allocatable_in),
        .fifo_wr_en              (fifo_wr_en),
        .fifo_wr_data            (fifo_wr_data),
        .fifo_afull              (fifo_afull),
        .pkt_done                (pkt_done),
        .pkt_err                 (pkt_err),
        .pkt_len                 (pkt_len)
    );

    always #5 clk_router = ~clk_router;

    function automatic logic [31:0] hdr(input logic [3:0] x, input logic [3:0] y, input logic [4:0] len);
        return {x, y, len, 19'h00abc};
    endfunction

    function automatic vec_t mk(input bit v, input logic [1:0] label, input logic [31:0] data,
                                input bit afull, input bit wr, input logic [31:0] wdata,
                                input bit done, input bit err, input bit on, input logic [4:0] len);
        vec_t r;
        r.v = v; r.label = label; r.data = data; r.afull = afull;
        r.wr = wr; r.wdata = wdata; r.done = done; r.err = err; r.on = on; r.len = len;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t r);
        string n;
        router_valid_out           = r.v;
        router_data_out.flit_label = flit_label_t'(r.label);
        router_data_out.vc_id      = 1'(idx);
        router_data_out.data       = r.data;
        fifo_afull                 = r.afull;
        @(posedge clk_router);
        #1;
        n = $sformatf("%s[%0d]", tag, idx);
        check({n, ".wr_en"}, 32'(fifo_wr_en), 32'(r.wr));
        if (r.wr) check({n, ".wr_data"}, fifo_wr_data, r.wdata);
        check({n, ".done"}, 32'(pkt_done), 32'(r.done));
        check({n, ".err"}, 32'(pkt_err), 32'(r.err));
        check({n, ".on_off"}, 32'(router_is_on_off_in), 32'({VC_NUM{r.on}}));
        check({n, ".len"}, 32'(pkt_len), 32'(r.len));
    endtask

    initial begin
        logic [31:0] h1, h2, h3, h4, h5, h6, h7, h8, h9;
        h1 = hdr(4'd2, 4'd3, 5'd2);
        h2 = hdr(4'd1, 4'd1, 5'd0);
        h3 = hdr(4'd5, 4'd6, 5'd2);
        h4 = hdr(4'd7, 4'd1, 5'd3);
        h5 = hdr(4'd3, 4'd3, 5'd0);
        h6 = hdr(4'd4, 4'd2, 5'd2);
        h7 = hdr(4'd1, 4'd2, 5'd2);
        h8 = hdr(4'd6, 4'd5, 5'd1);
        h9 = hdr(4'd2, 4'd2, 5'd0);

        // T1 back-to-back len=2 packet
        tab1.push_back(mk(1, HEAD, h1,    0, 0, 0,     0, 0, 1, 0));
        tab1.push_back(mk(1, BODY, 'hA,   0, 1, h1,    0, 0, 1, 2));
        tab1.push_back(mk(1, BODY, 'hB,   0, 1, 'hA,   0, 0, 1, 2));
        tab1.push_back(mk(1, TAIL, 'hC,   0, 1, 'hB,   0, 0, 1, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'hC,   1, 0, 1, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 0, 1, 2));
        // T2 len=0 packet
        tab1.push_back(mk(1, HEAD, h2,    0, 0, 0,     0, 0, 1, 2));
        tab1.push_back(mk(1, TAIL, 'hD,   0, 1, h2,    0, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'hD,   1, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 0, 1, 0));
        // T3 stall with afull, fill to 4, then drain
        tab1.push_back(mk(1, HEAD, h3,    1, 0, 0,     0, 0, 1, 0));
        tab1.push_back(mk(1, BODY, 'hE,   1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(1, BODY, 'hF,   1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(1, TAIL, 'h10,  1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(0, BODY, 0,     1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 1, h3,    0, 0, 0, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'hE,   0, 0, 0, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'hF,   0, 0, 1, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'h10,  1, 0, 1, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 0, 1, 2));
        // T4 early tail, then clean packet
        tab1.push_back(mk(1, HEAD, h4,    0, 0, 0,     0, 0, 1, 2));
        tab1.push_back(mk(1, BODY, 'h11,  0, 1, h4,    0, 0, 1, 3));
        tab1.push_back(mk(1, TAIL, 'h12,  0, 1, 'h11,  0, 0, 1, 3));
        tab1.push_back(mk(1, HEAD, h5,    0, 1, 'h12,  0, 1, 1, 3));
        tab1.push_back(mk(1, TAIL, 'h13,  0, 1, h5,    0, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'h13,  1, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 0, 1, 0));
        // T5 BODY in IDLE, overflow drop, push+pop at full
        tab1.push_back(mk(1, BODY, 'h14,  0, 0, 0,     0, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 1, 1, 0));
        tab1.push_back(mk(1, HEAD, h6,    1, 0, 0,     0, 0, 1, 0));
        tab1.push_back(mk(1, BODY, 'h15,  1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(1, BODY, 'h16,  1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(1, TAIL, 'h17,  1, 0, 0,     0, 0, 0, 0));
        tab1.push_back(mk(1, BODY, 'hDEAD,1, 0, 0,     0, 1, 0, 0));
        tab1.push_back(mk(1, HEAD, h9,    0, 1, h6,    0, 0, 0, 2));
        tab1.push_back(mk(1, TAIL, 'h18,  0, 1, 'h15,  0, 0, 0, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'h16,  0, 0, 0, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'h17,  1, 0, 0, 2));
        tab1.push_back(mk(0, BODY, 0,     0, 1, h9,    0, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 1, 'h18,  1, 0, 1, 0));
        tab1.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 0, 1, 0));
        // T6 packet after mid-packet reset: the pre-reset BODY must not appear
        tab2.push_back(mk(1, HEAD, h8,    0, 0, 0,     0, 0, 1, 0));
        tab2.push_back(mk(1, BODY, 'h19,  0, 1, h8,    0, 0, 1, 1));
        tab2.push_back(mk(1, TAIL, 'h1A,  0, 1, 'h19,  0, 0, 1, 1));
        tab2.push_back(mk(0, BODY, 0,     0, 1, 'h1A,  1, 0, 1, 1));
        tab2.push_back(mk(0, BODY, 0,     0, 0, 0,     0, 0, 1, 1));

        router_data_out = '0;
        #22;
        check("reset.wr_en", 32'(fifo_wr_en), 32'd0);
        check("reset.wr_data", fifo_wr_data, 32'd0);
        check("reset.done", 32'(pkt_done), 32'd0);
        check("reset.err", 32'(pkt_err), 32'd0);
        check("reset.len", 32'(pkt_len), 32'd0);
        check("reset.on_off", 32'(router_is_on_off_in), 32'({VC_NUM{1'b1}}));
        check("reset.alloc", 32'(router_is_allocatable_in), 32'({VC_NUM{1'b1}}));
        rst_router = 1'b0;
        @(posedge clk_router);
        #1;

        foreach (tab1[i]) run_vec("tab1", i, tab1[i]);

        // Mid-payload reset
        run_vec("t6pre", 0, mk(1, HEAD, h7,   0, 0, 0,  0, 0, 1, 0));
        run_vec("t6pre", 1, mk(1, BODY, 'h1B, 0, 1, h7, 0, 0, 1, 2));
        router_valid_out = 1'b0;
        rst_router = 1'b1;
        #2;
        check("t6rst.wr_en", 32'(fifo_wr_en), 32'd0);
        check("t6rst.wr_data", fifo_wr_data, 32'd0);
        check("t6rst.done", 32'(pkt_done), 32'd0);
        check("t6rst.err", 32'(pkt_err), 32'd0);
        check("t6rst.len", 32'(pkt_len), 32'd0);
        check("t6rst.on_off", 32'(router_is_on_off_in), 32'({VC_NUM{1'b1}}));
        @(posedge clk_router);
        #1;
        rst_router = 1'b0;

        foreach (tab2[i]) run_vec("tab2", i, tab2[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
